read_status_handler: RTL and testbench

Read-domain pointer and status block for the dual-clock FIFO, generalised from the basic read/empty handler. It synchronises the Gray-coded write pointer into rclk with a configurable synchroniser depth and advances the read pointer. From that it produces registered empty, programmable almost-empty and occupancy-level outputs, plus an optional sticky underflow flag. It sits between the FIFO memory read port and the read-side consumer; its Gray rptr feeds the write-domain full handler.

---
 rtl/read_status_handler.sv | 153 +++++++++++++++
 tb/tb_read_status_handler.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/read_status_handler.sv
// -----------------------------------------------------------------------------
// read_status_handler
//
// Read-domain pointer and status block of a dual-clock FIFO.
// - Brings the Gray-coded write pointer into the rclk domain through a
//   synchroniser chain of SYNC_STAGES flops.
// - Advances the read pointer.
// - Produces registered empty, almost-empty and occupancy-level outputs.
// - Optionally provides a sticky underflow flag, enabled by defining the
//   macro RD_UNDERFLOW_FLAG_EN.
//
// Handshake: rinc is the consumer's request and rread is the accept.
// - rread = rinc & !rempty and is combinational.
// - An entry is consumed on an rclk edge exactly when rread=1 before that edge.
// - raddr addresses that entry during the cycle and advances on the same edge.
// - A request made while rempty=1 is ignored.
//
// Parameters
//   PS           pointer address width; depth = 2^PS; pointers are PS+1 bits
//   SYNC_STAGES  flops in the wptr synchroniser (2 or more)
//
// Ports
//   rclk         read clock
//   rrst_n       asynchronous active-low reset
//   rinc         read request from the consumer
//   wptr_gray    Gray write pointer from the wclk domain (asynchronous)
//   raempty_thr  almost-empty threshold (quasi-static)
//   rclr_uflow   clears runderflow (ignored when the flag is disabled)
//   rread        combinational read accept
//   raddr        memory read address
//   rptr         registered Gray read pointer, to the write domain
//   rempty       registered empty flag
//   raempty      registered almost-empty flag
//   rlevel       registered occupancy, 0..2^PS
//   runderflow   sticky underflow flag (0 when RD_UNDERFLOW_FLAG_EN is undefined)
// -----------------------------------------------------------------------------
module read_status_handler #(
   parameter int PS          = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic          rclk,
   input  logic          rrst_n,
   input  logic          rinc,
   input  logic [PS:0]   wptr_gray,
   input  logic [PS:0]   raempty_thr,
   input  logic          rclr_uflow,
   output logic          rread,
   output logic [PS-1:0] raddr,
   output logic [PS:0]   rptr,
   output logic          rempty,
   output logic          raempty,
   output logic [PS:0]   rlevel,
   output logic          runderflow
);

   generate
      if (SYNC_STAGES < 2) begin : g_bad_sync_stages
         $error("read_status_handler: SYNC_STAGES must be 2 or more");
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // Write-pointer synchroniser
   // ---------------------------------------------------------------------------
   logic [PS:0] sync_q [SYNC_STAGES];
   logic [PS:0] rq_wptr;
   logic [PS:0] wq_bin;

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= wptr_gray;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign rq_wptr = sync_q[SYNC_STAGES-1];

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      wq_bin = '0;
      for (int i = 0; i <= PS; i++) wq_bin[i] = ^(rq_wptr >> i);
   end

   // ---------------------------------------------------------------------------
   // Read pointer and status
   // ---------------------------------------------------------------------------
   logic [PS:0] b_rptr_q, b_rptr_d;
   logic [PS:0] rptr_q, rptr_d;
   logic [PS:0] rlevel_q, rlevel_d;
   logic        rempty_q, rempty_d;
   logic        raempty_q, raempty_d;

   assign rread = rinc & ~rempty_q;

   // The status is derived from the post-read pointer, so a read lowers the
   // status on the same edge that consumes the entry. Empty can therefore
   // never be late in the read direction.
   assign b_rptr_d  = b_rptr_q + {{PS{1'b0}}, rread};
   assign rptr_d    = b_rptr_d ^ (b_rptr_d >> 1);
   assign rlevel_d  = wq_bin - b_rptr_d;
   assign rempty_d  = (rptr_d == rq_wptr);
   assign raempty_d = (rlevel_d <= raempty_thr);

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         b_rptr_q  <= '0;
         rptr_q    <= '0;
         rlevel_q  <= '0;
         rempty_q  <= 1'b1;
         raempty_q <= 1'b1;
      end else begin
         b_rptr_q  <= b_rptr_d;
         rptr_q    <= rptr_d;
         rlevel_q  <= rlevel_d;
         rempty_q  <= rempty_d;
         raempty_q <= raempty_d;
      end
   end

   assign raddr   = b_rptr_q[PS-1:0];
   assign rptr    = rptr_q;
   assign rempty  = rempty_q;
   assign raempty = raempty_q;
   assign rlevel  = rlevel_q;

   // ---------------------------------------------------------------------------
   // Optional sticky underflow flag
   // ---------------------------------------------------------------------------
`ifdef RD_UNDERFLOW_FLAG_EN
   logic runderflow_q, runderflow_d;

   // The set is applied after the clear, so a set on the same edge wins.
   always_comb begin
      runderflow_d = runderflow_q;
      if (rclr_uflow)         runderflow_d = 1'b0;
      if (rinc && rempty_q)   runderflow_d = 1'b1;
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) runderflow_q <= 1'b0;
      else         runderflow_q <= runderflow_d;
   end

   assign runderflow = runderflow_q;
`else
   logic unused_rclr_uflow;
   assign unused_rclr_uflow = rclr_uflow;
   assign runderflow        = 1'b0;
`endif

endmodule

// File: tb/tb_read_status_handler.sv
// -----------------------------------------------------------------------------
// tb_read_status_handler
//
// Directed bench for read_status_handler with PS=4 and SYNC_STAGES=2.
// - A table of per-cycle vectors covers the full drain and the
//   threshold corner cases.
// - Hand-written sequences cover reset, a single write, underflow,
//   simultaneous read/write and pointer wrap-around.
//
// Timing used by the bench:
// - Inputs change 1 ns after a rising edge.
// - rread is checked 1 ns after the inputs change.
// - Registered outputs are checked 1 ns after the following rising edge.
// -----------------------------------------------------------------------------
module tb_read_status_handler;

   localparam int PS = 4;

   logic          rclk;
   logic          rrst_n;
   logic          rinc;
   logic [PS:0]   wptr_gray;
   logic [PS:0]   raempty_thr;
   logic          rclr_uflow;
   logic          rread;
   logic [PS-1:0] raddr;
   logic [PS:0]   rptr;
   logic          rempty;
   logic          raempty;
   logic [PS:0]   rlevel;
   logic          runderflow;

   int n_total = 0;
   int n_pass  = 0;

   read_status_handler #(.PS(PS), .SYNC_STAGES(2)) dut (
      .rclk        (rclk),
      .rrst_n      (rrst_n),
      .rinc        (rinc),
      .wptr_gray   (wptr_gray),
      .raempty_thr (raempty_thr),
      .rclr_uflow  (rclr_uflow),
      .rread       (rread),
      .raddr       (raddr),
      .rptr        (rptr),
      .rempty      (rempty),
      .raempty     (raempty),
      .rlevel      (rlevel),
      .runderflow  (runderflow)
   );

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   // ---------------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------------
   task automatic tick();
      @(posedge rclk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [4:0] gray(input int unsigned v);
      logic [4:0] b;
      b = v[4:0];
      return b ^ (b >> 1);
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_rempty"},     int'(rempty),     1);
      chk({tag, "_raempty"},    int'(raempty),    1);
      chk({tag, "_rlevel"},     int'(rlevel),     0);
      chk({tag, "_rptr"},       int'(rptr),       0);
      chk({tag, "_raddr"},      int'(raddr),      0);
      chk({tag, "_runderflow"}, int'(runderflow), 0);
   endtask

   task automatic do_reset(input logic [4:0] w);
      rrst_n    = 1'b0;
      wptr_gray = w;
      tick();
      tick();
      rrst_n = 1'b1;
   endtask

   // ---------------------------------------------------------------------------
   // Vector table
   // ---------------------------------------------------------------------------
   typedef struct {
      logic       rinc;
      logic [4:0] wptr;
      logic [4:0] thr;
      logic       e_rread;
      logic       e_rempty;
      logic       e_raempty;
      logic [4:0] e_rlevel;
      logic [3:0] e_raddr;
      logic [4:0] e_rptr;
   } vec_t;

   localparam int NV = 25;
   vec_t vecs [NV];

   // Scoreboard for the wrap-around read pointer
   logic [4:0] exp_q [$];

   // Per-cycle monitor state for the wrap-around sequence
   logic [4:0] prev_rptr;
   logic [3:0] prev_raddr;
   int         msb_toggles;
   int         addr_wraps;

   task automatic mon_tick();
      tick();
      chk("wrap_rlevel_le_16", int'(rlevel <= 5'd16), 1);
      if (rptr != prev_rptr) begin
         chk("wrap_rptr_1bit", $countones(rptr ^ prev_rptr), 1);
         if (rptr[4] != prev_rptr[4]) msb_toggles++;
      end
      if (prev_raddr == 4'd15 && raddr == 4'd0) addr_wraps++;
      prev_rptr  = rptr;
      prev_raddr = raddr;
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      int rd_cnt;
      int wr_cnt;
      logic [4:0] exp_ptr;

      // Full drain: Gray(16) is written, it takes two edges to reach the
      // synchroniser output, and the status follows one edge later.
      vecs[0]  = '{1'b0, 5'b11000, 5'd3, 1'b0, 1'b1, 1'b1, 5'd0,  4'd0,  5'b00000};
      vecs[1]  = '{1'b0, 5'b11000, 5'd3, 1'b0, 1'b1, 1'b1, 5'd0,  4'd0,  5'b00000};
      vecs[2]  = '{1'b0, 5'b11000, 5'd3, 1'b0, 1'b0, 1'b0, 5'd16, 4'd0,  5'b00000};
      // 16 back-to-back reads; raempty rises when the level reaches 3
      vecs[3]  = '{1'b1, 5'b11000, 5'd3, 1'b1, 1'b0, 1'b0, 5'd15, 4'd1,  5'b00001};
      vecs[4]  = '{1'b1, 5'b11000, 5'd3, 1'b1, 1'b0, 1'b0, 5'd14, 4'd2,  5'b00011};
      vecs[5]  = '{1'b1, 5'b11000, 5'd3, 1'b1, 1'b0, 1'b0, 5'd13, 4'd3,  5'b00010};
      vecs[6]  = '{1'b1, 5'b11000, 5'd3, 1'b1, 1'b0, 1'b0, 5'd12, 4'd4,  5'b00110};
      vecs[7]  = '{1'b1, 5'b11000, 5'd3, 1'b1, 1'b0, 1'b0, 5'd11, 4'd5,  5'b00111};
      vecs[8]  = '{1'b1, 5'b11000, 5'd3, 1'b1, 1'b0, 1'b0, 5'd10, 4'd6,  5'b00101};
      vecs[9]  = '{1'b1, 5'b11000, 5'd3, 1'b1, 1'b0, 1'b0, 5'd9,  4'd7,  5'b00100};
      vecs[10] = '{1'b1, 5'b11000, 5'd3, 1'b1, 1'b0, 1'b0, 5'd8,  4'd8,  5'b01100};
      vecs[11] = '{1'b1, 5'b11000, 5'd3, 1'b1, 1'b0, 1'b0, 5'd7,  4'd9,  5'b01101};
      vecs[12] = '{1'b1, 5'b11000, 5'd3, 1'b1, 1'b0, 1'b0, 5'd6,  4'd10, 5'b01111};
      vecs[13] = '{1'b1, 5'b11000, 5'd3, 1'b1, 1'b0, 1'b0, 5'd5,  4'd11, 5'b01110};
      vecs[14] = '{1'b1, 5'b11000, 5'd3, 1'b1, 1'b0, 1'b0, 5'd4,  4'd12, 5'b01010};
      vecs[15] = '{1'b1, 5'b11000, 5'd3, 1'b1, 1'b0, 1'b1, 5'd3,  4'd13, 5'b01011};
      vecs[16] = '{1'b1, 5'b11000, 5'd3, 1'b1, 1'b0, 1'b1, 5'd2,  4'd14, 5'b01001};
      vecs[17] = '{1'b1, 5'b11000, 5'd3, 1'b1, 1'b0, 1'b1, 5'd1,  4'd15, 5'b01000};
      vecs[18] = '{1'b1, 5'b11000, 5'd3, 1'b1, 1'b1, 1'b1, 5'd0,  4'd0,  5'b11000};
      // Request while empty is ignored
      vecs[19] = '{1'b1, 5'b11000, 5'd3, 1'b0, 1'b1, 1'b1, 5'd0,  4'd0,  5'b11000};
      // Threshold 0 tracks rempty; threshold 16 pins raempty at 1
      vecs[20] = '{1'b0, 5'b11001, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0,  4'd0,  5'b11000};
      vecs[21] = '{1'b0, 5'b11001, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0,  4'd0,  5'b11000};
      vecs[22] = '{1'b0, 5'b11001, 5'd0, 1'b0, 1'b0, 1'b0, 5'd1,  4'd0,  5'b11000};
      vecs[23] = '{1'b0, 5'b11001, 5'd16,1'b0, 1'b0, 1'b1, 5'd1,  4'd0,  5'b11000};
      vecs[24] = '{1'b1, 5'b11001, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0,  4'd1,  5'b11001};

      // ---- Initial reset --------------------------------------------------
      rrst_n      = 1'b1;
      rinc        = 1'b0;
      wptr_gray   = '0;
      raempty_thr = 5'd3;
      rclr_uflow  = 1'b0;
      #2 rrst_n = 1'b0;
      #1;
      chk_reset_vals("init");
      rinc = 1'b1;
      #1 chk("init_rread_while_empty", int'(rread), 0);
      rinc = 1'b0;
      tick();
      tick();
      rrst_n = 1'b1;

      // ---- Single write then one read -------------------------------------
      wptr_gray = 5'b00001;
      tick();
      chk("sw_rempty_edge1", int'(rempty), 1);
      tick();
      chk("sw_rempty_edge2", int'(rempty), 1);
      tick();
      chk("sw_rempty_edge3", int'(rempty), 0);
      chk("sw_rlevel", int'(rlevel), 1);
      chk("sw_raempty", int'(raempty), 1);
      rinc = 1'b1;
      #1;
      chk("sw_rread", int'(rread), 1);
      chk("sw_raddr_before", int'(raddr), 0);
      tick();
      rinc = 1'b0;
      chk("sw_raddr_after", int'(raddr), 1);
      chk("sw_rempty_after", int'(rempty), 1);
      chk("sw_rlevel_after", int'(rlevel), 0);
      chk("sw_rptr_after", int'(rptr), 1);

      // ---- Underflow ------------------------------------------------------
      rinc = 1'b1;
      #1 chk("uf_rread", int'(rread), 0);
      tick();
      chk("uf_raddr_hold", int'(raddr), 1);
      chk("uf_rptr_hold", int'(rptr), 1);
`ifdef RD_UNDERFLOW_FLAG_EN
      chk("uf_set", int'(runderflow), 1);
`else
      chk("uf_disabled_0", int'(runderflow), 0);
`endif
      rclr_uflow = 1'b1;
      tick();
`ifdef RD_UNDERFLOW_FLAG_EN
      chk("uf_set_wins", int'(runderflow), 1);
`else
      chk("uf_disabled_1", int'(runderflow), 0);
`endif
      rinc = 1'b0;
      tick();
      chk("uf_cleared", int'(runderflow), 0);
      rclr_uflow = 1'b0;

      // ---- Table: full drain and thresholds -------------------------------
      do_reset(5'b00000);
      for (int i = 0; i < NV; i++) begin
         rinc        = vecs[i].rinc;
         wptr_gray   = vecs[i].wptr;
         raempty_thr = vecs[i].thr;
         #1;
         chk($sformatf("v%0d_rread", i), int'(rread), int'(vecs[i].e_rread));
         tick();
         chk($sformatf("v%0d_rempty", i),  int'(rempty),  int'(vecs[i].e_rempty));
         chk($sformatf("v%0d_raempty", i), int'(raempty), int'(vecs[i].e_raempty));
         chk($sformatf("v%0d_rlevel", i),  int'(rlevel),  int'(vecs[i].e_rlevel));
         chk($sformatf("v%0d_raddr", i),   int'(raddr),   int'(vecs[i].e_raddr));
         chk($sformatf("v%0d_rptr", i),    int'(rptr),    int'(vecs[i].e_rptr));
      end
      rinc        = 1'b0;
      raempty_thr = 5'd3;

      // ---- Simultaneous write arrival and read ----------------------------
      // Read count 17, write count 17. Write #18 makes level 1.
      wptr_gray = gray(18);
      tick(); tick(); tick();
      chk("sim_pre_rempty", int'(rempty), 0);
      chk("sim_pre_rlevel", int'(rlevel), 1);
      wptr_gray = gray(19);
      tick(); tick();
      // Write #19 now sits at the synchroniser output; the read lands on the
      // same edge that the level picks it up.
      chk("sim_stale_rlevel", int'(rlevel), 1);
      rinc = 1'b1;
      #1 chk("sim_rread", int'(rread), 1);
      tick();
      rinc = 1'b0;
      chk("sim_rempty", int'(rempty), 0);
      chk("sim_rlevel", int'(rlevel), 1);
      chk("sim_raddr", int'(raddr), 2);
      chk("sim_rptr", int'(rptr), int'(gray(18)));
      rinc = 1'b1;
      tick();
      rinc = 1'b0;
      chk("sim_drain_rempty", int'(rempty), 1);
      chk("sim_drain_raddr", int'(raddr), 3);

      // ---- Wrap-around: 40 write/read pairs -------------------------------
      rd_cnt      = 19;
      wr_cnt      = 19;
      prev_rptr   = rptr;
      prev_raddr  = raddr;
      msb_toggles = 0;
      addr_wraps  = 0;
      for (int p = 0; p < 40; p++) begin
         wr_cnt++;
         wptr_gray = gray(wr_cnt);
         mon_tick(); mon_tick(); mon_tick();
         chk("wrap_rempty_0", int'(rempty), 0);
         chk("wrap_rlevel_1", int'(rlevel), 1);
         rinc = 1'b1;
         #1 chk("wrap_rread", int'(rread), 1);
         exp_q.push_back(gray(rd_cnt + 1));
         mon_tick();
         rinc = 1'b0;
         rd_cnt++;
         exp_ptr = exp_q.pop_front();
         chk("wrap_rptr", int'(rptr), int'(exp_ptr));
         chk("wrap_raddr", int'(raddr), rd_cnt % 16);
         chk("wrap_rempty_1", int'(rempty), 1);
      end
      chk("wrap_msb_toggles", msb_toggles, 2);
      chk("wrap_raddr_wraps", addr_wraps, 2);

      // ---- Reset mid-operation --------------------------------------------
      wr_cnt++;
      wptr_gray = gray(wr_cnt);
      tick(); tick(); tick();
      chk("mr_pre_rempty", int'(rempty), 0);
      @(negedge rclk);
      wptr_gray = 5'b00011;
      rrst_n    = 1'b0;
      #1;
      chk_reset_vals("midrst");
      tick();
      tick();
      rrst_n = 1'b1;
      tick();
      chk("mr_rempty_edge1", int'(rempty), 1);
      tick();
      chk("mr_rempty_edge2", int'(rempty), 1);
      tick();
      chk("mr_rempty_edge3", int'(rempty), 0);
      chk("mr_rlevel", int'(rlevel), 2);
      chk("mr_raempty", int'(raempty), 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
